// File: rtl/gf_horner_16_pkg.sv
// Shared constants for the GF(2^16) Horner evaluator: field width,
// reduction polynomial, FSM state encoding and a field doubling helper.
package gf_horner_16_pkg;

  localparam int GF16_W = 16;

  // Low 16 bits of the reduction polynomial x^16 + x^12 + x^3 + x + 1.
  localparam logic [GF16_W-1:0] GF16_POLY = 16'h100B;

  // Bit-serial multiplier iteration counter width (counts 16 down to 0).
  localparam int MUL_CNT_W = 5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ACC  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Multiply a field element by x and reduce modulo the field polynomial.
  function automatic logic [GF16_W-1:0] gf16_xtime(input logic [GF16_W-1:0] a);
    return {a[GF16_W-2:0], 1'b0} ^ (a[GF16_W-1] ? GF16_POLY : '0);
  endfunction

endpackage

// File: rtl/gf_mul_16.sv
// Bit-serial GF(2^16) multiplier, MSB-first shift-and-add.
// A start accepted while idle produces o_done 17 cycles later (start
// cycle to done cycle); o_p holds the product until the next start.
module gf_mul_16
  import gf_horner_16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [GF16_W-1:0] i_x,
  input  logic [GF16_W-1:0] i_y,
  output logic [GF16_W-1:0] o_p,
  output logic              o_done
);

  logic [GF16_W-1:0]    r_a;
  logic [GF16_W-1:0]    r_b;
  logic [GF16_W-1:0]    r_p;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic                 r_done;

  // Capture operands on start, then fold in one bit of i_y per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_p   <= gf16_xtime(r_p) ^ (r_b[GF16_W-1] ? r_a : '0);
        r_b   <= {r_b[GF16_W-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == MUL_CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_a    <= i_x;
        r_b    <= i_y;
        r_p    <= '0;
        r_cnt  <= MUL_CNT_W'(GF16_W);
        r_busy <= 1'b1;
      end
    end
  end

  assign o_p    = r_p;
  assign o_done = r_done;

endmodule

// File: rtl/gf_horner_16.sv
// Evaluates P(x) = sum c[k]*x^k over GF(2^16) by Horner's rule, reading
// coefficients from an external one-cycle-latency memory and using a
// single shared multiplier whose latency the FSM simply waits out.
//
// state  | meaning
// IDLE   | waiting for i_start; read of c[d] issued on accept
// LOAD   | c[d] arrives, becomes the accumulator
// MUL    | start acc*x, issue read of c[k]
// WAIT   | latch c[k], wait for the product
// ACC    | acc = product ^ c[k]; next k or finish
// DONE   | o_y valid, o_done pulse
module gf_horner_16
  import gf_horner_16_pkg::*;
#(
  parameter int N_COEF = 256,
  parameter int ADDR_W = $clog2(N_COEF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [GF16_W-1:0] i_x,
  input  logic [ADDR_W-1:0] i_deg,
  output logic [ADDR_W-1:0] o_coef_addr,
  output logic              o_coef_rd_en,
  input  logic [GF16_W-1:0] i_coef,
  output logic [GF16_W-1:0] o_y,
  output logic              o_done,
  output logic              o_busy
);

  logic [2:0]        r_state;
  logic [GF16_W-1:0] r_x;
  logic [ADDR_W-1:0] r_d;
  logic [ADDR_W-1:0] r_k;
  logic [GF16_W-1:0] r_acc;
  logic [GF16_W-1:0] r_ck;
  logic [GF16_W-1:0] r_y;
  logic              r_rd_q;

  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [GF16_W-1:0] w_prod;

  // Reset gating keeps the read strobe and address at zero while reset is held.
  assign w_accept    = (r_state == S_IDLE) && i_start && !i_rst;
  assign w_mul_start = (r_state == S_MUL);

  // Read strobe/address: c[d] on accept, c[k] alongside each multiply.
  always_comb begin
    o_coef_rd_en = w_accept || w_mul_start;
    o_coef_addr  = '0;
    if (w_accept)
      o_coef_addr = i_deg;
    else if (w_mul_start)
      o_coef_addr = r_k;
  end

  // Remember that a read was issued last cycle so WAIT knows when c[k] lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_rd_q <= 1'b0;
    else
      r_rd_q <= o_coef_rd_en;
  end

  // Horner sequencing; o_y is loaded on entry to DONE so it is valid with o_done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_d     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_ck    <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x     <= i_x;
            r_d     <= i_deg;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc <= i_coef;
          if (r_d == '0) begin
            r_y     <= i_coef;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_d - 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_rd_q)
            r_ck <= i_coef;
          if (w_mul_done)
            r_state <= S_ACC;
        end
        S_ACC: begin
          r_acc <= w_prod ^ r_ck;
          if (r_k == '0) begin
            r_y     <= w_prod ^ r_ck;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k - 1'b1;
            r_state <= S_MUL;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  gf_mul_16 u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_mul_start),
    .i_x     (r_acc),
    .i_y     (r_x),
    .o_p     (w_prod),
    .o_done  (w_mul_done)
  );

  assign o_y    = r_y;
  assign o_done = (r_state == S_DONE);
  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_gf_horner_16.sv
// Bench for gf_horner_16: polynomial-arithmetic reference model, per-cycle
// compare process on o_done / read strobes, plus literal expectations.
module tb_gf_horner_16;

  localparam int L_MUL = 17;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_x;
  logic [7:0]  i_deg;
  logic [7:0]  o_coef_addr;
  logic        o_coef_rd_en;
  logic [15:0] i_coef;
  logic [15:0] o_y;
  logic        o_done;
  logic        o_busy;

  gf_horner_16 dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_x          (i_x),
    .i_deg        (i_deg),
    .o_coef_addr  (o_coef_addr),
    .o_coef_rd_en (o_coef_rd_en),
    .i_coef       (i_coef),
    .o_y          (o_y),
    .o_done       (o_done),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_d = 0;
  int exp_lat = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;
  logic [15:0] exp_y = '0;
  logic [15:0] last_y = '0;
  logic prev_done = 1'b0;
  logic [15:0] mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  // coefficient memory, one cycle read latency
  always @(posedge clk) if (o_coef_rd_en) i_coef <= mem[o_coef_addr];

  // carry-less product followed by polynomial reduction
  function automatic logic [15:0] gf_mul_m(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p ^ (32'(a) << i);
    for (int i = 30; i >= 16; i--)
      if (p[i]) p = p ^ (32'h0001100B << (i - 16));
    return p[15:0];
  endfunction

  function automatic logic [15:0] horner_m(input logic [15:0] x, input int d);
    logic [15:0] acc;
    acc = mem[d];
    for (int k = d - 1; k >= 0; k--)
      acc = gf_mul_m(acc, x) ^ mem[k];
    return acc;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (o_coef_rd_en) begin
      rd_cnt++;
      checks++;
      if (int'(o_coef_addr) > exp_d) begin
        failures++;
        $display("FAIL addr_range: got %0d expected <= %0d", o_coef_addr, exp_d);
      end
    end
    if (prev_done) begin
      checks++;
      if (o_busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_after_done: got %b expected 0", o_busy);
      end
    end
    if (o_done) begin
      done_cnt++;
      last_y = o_y;
      checks += 4;
      if (o_y !== exp_y) begin
        failures++;
        $display("FAIL result: got %h expected %h", o_y, exp_y);
      end
      if (cyc - start_cyc != exp_lat) begin
        failures++;
        $display("FAIL latency: got %0d expected %0d", cyc - start_cyc, exp_lat);
      end
      if (o_busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_at_done: got %b expected 1", o_busy);
      end
      if (rd_cnt != exp_d + 1) begin
        failures++;
        $display("FAIL read_count: got %0d expected %0d", rd_cnt, exp_d + 1);
      end
    end
    prev_done = o_done;
  end

  task automatic kick(input logic [15:0] x, input int d);
    @(posedge clk) #1;
    exp_d = d;
    exp_y = horner_m(x, d);
    exp_lat = (d == 0) ? 2 : 2 + d * (L_MUL + 2);
    rd_cnt = 0;
    start_cyc = cyc;
    i_start = 1'b1;
    i_x = x;
    i_deg = 8'(d);
    @(posedge clk) #1;
    i_start = 1'b0;
    i_x = 16'($urandom);
    i_deg = 8'($urandom);
  endtask

  task automatic run(input logic [15:0] x, input int d, input bit noise);
    bit got;
    got = 1'b0;
    kick(x, d);
    exp_done_cnt++;
    for (int i = 0; i < exp_lat + 20; i++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk) #1;
      if (noise) begin
        i_start = 1'($urandom_range(0, 1));
        i_x = 16'($urandom);
        i_deg = 8'($urandom);
      end
    end
    #1;
    i_start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no o_done expected done within %0d cycles", exp_lat + 20);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_y"}, o_y, 16'h0000);
    chk({tag, "_done"}, 16'(o_done), 16'h0000);
    chk({tag, "_busy"}, 16'(o_busy), 16'h0000);
    chk({tag, "_rd_en"}, 16'(o_coef_rd_en), 16'h0000);
    chk({tag, "_addr"}, 16'(o_coef_addr), 16'h0000);
  endtask

  int done_before;

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_x = '0;
    i_deg = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // hand-computed values pinning the reference model
    chk("model_mul_reduce", gf_mul_m(16'h8000, 16'h0002), 16'h100B);
    chk("model_mul_small", gf_mul_m(16'h0003, 16'h0003), 16'h0005);

    // d = 0
    mem[0] = 16'hBEEF;
    run(16'h1234, 0, 1'b0);
    chk("d0_literal", last_y, 16'hBEEF);

    // all-zero coefficients
    for (int i = 0; i < 256; i++) mem[i] = '0;
    run(16'h1234, 5, 1'b0);
    chk("zero_coef_literal", last_y, 16'h0000);

    // x = 1 and x = 0 over {1,2,4,8}
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0004; mem[3] = 16'h0008;
    chk("model_horner_x1", horner_m(16'h0001, 3), 16'h000F);
    run(16'h0001, 3, 1'b0);
    chk("x1_literal", last_y, 16'h000F);
    run(16'h0000, 3, 1'b0);
    chk("x0_literal", last_y, 16'h0001);

    // back-to-back pair over {3,5,7}: 3^5^7 = 1, and ((7*2)^5)*2^3 = 0x15
    mem[0] = 16'h0003; mem[1] = 16'h0005; mem[2] = 16'h0007;
    run(16'h0001, 2, 1'b0);
    chk("b2b_first_literal", last_y, 16'h0001);
    run(16'h0002, 2, 1'b0);
    chk("b2b_second_literal", last_y, 16'h0015);

    // reset during WAIT of a d=4 run
    for (int i = 0; i < 5; i++) mem[i] = 16'($urandom);
    done_before = done_cnt;
    kick(16'h0777, 4);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (120) @(posedge clk);
    chk("no_done_after_abort", 16'(done_cnt - done_before), 16'h0000);
    mem[0] = 16'h0055;
    run(16'h9999, 0, 1'b0);
    chk("restart_literal", last_y, 16'h0055);

    // full-depth random polynomial with ignored starts while busy
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    run(16'h2222, 255, 1'b1);

    repeat (3) @(posedge clk);
    chk("done_pulse_count", 16'(done_cnt), 16'(exp_done_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
